// File: rtl/alarm_controller.sv
// Alarm scheduler: BCD alarm time edit, match detect,
// ring / snooze / stop sequencing in the 1 Hz domain.
module alarm_controller #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic [1:0] hour_ten,
  input  logic [3:0] hour_unit,
  input  logic [3:0] min_ten,
  input  logic [3:0] min_unit,
  input  logic [3:0] sec_ten,
  input  logic [3:0] sec_unit,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       sel,
  input  logic       up,
  input  logic       down,
  input  logic       snooze,
  input  logic       stop,
  output logic [1:0] alm_hour_ten,
  output logic [3:0] alm_hour_unit,
  output logic [3:0] alm_min_ten,
  output logic [3:0] alm_min_unit,
  output logic       field_sel,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] state
);

  localparam int SNZ_W = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int USE_W = $clog2(MAX_SNOOZE + 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * 60);
  localparam logic [USE_W-1:0] USE_MAX = USE_W'(MAX_SNOOZE);
  localparam logic [7:0] RING_MAX = 8'(RING_TIMEOUT_S);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t           st, st_n;
  logic [7:0]       ring_cnt, ring_n;
  logic [SNZ_W-1:0] snz_cnt, snz_n;
  logic [USE_W-1:0] use_cnt, use_n;
  logic             match_c, match_q, match_ev;

  logic [1:0] ht_n;
  logic [3:0] hu_n, mt_n, mu_n;
  logic       fs_n;

  assign state = st;

  assign match_c = alarm_en && !set_mode &&
                   hour_ten == alm_hour_ten &&
                   hour_unit == alm_hour_unit &&
                   min_ten == alm_min_ten &&
                   min_unit == alm_min_unit &&
                   sec_ten == 4'd0 &&
                   sec_unit == 4'd0;
  assign match_ev = match_c && !match_q;

  // Next alarm digits from the edit buttons, BCD per digit
  always_comb begin
    ht_n = alm_hour_ten;
    hu_n = alm_hour_unit;
    mt_n = alm_min_ten;
    mu_n = alm_min_unit;
    fs_n = field_sel;
    if (set_mode) begin
      if (sel) fs_n = ~field_sel;
      if (up && !down) begin
        if (!field_sel) begin
          if (alm_hour_ten == 2'd2 &&
              alm_hour_unit == 4'd3) begin
            ht_n = 2'd0;
            hu_n = 4'd0;
          end else if (alm_hour_unit == 4'd9) begin
            ht_n = alm_hour_ten + 2'd1;
            hu_n = 4'd0;
          end else begin
            hu_n = alm_hour_unit + 4'd1;
          end
        end else begin
          if (alm_min_unit == 4'd9) begin
            mu_n = 4'd0;
            mt_n = (alm_min_ten == 4'd5) ?
                   4'd0 : alm_min_ten + 4'd1;
          end else begin
            mu_n = alm_min_unit + 4'd1;
          end
        end
      end else if (down && !up) begin
        if (!field_sel) begin
          if (alm_hour_ten == 2'd0 &&
              alm_hour_unit == 4'd0) begin
            ht_n = 2'd2;
            hu_n = 4'd3;
          end else if (alm_hour_unit == 4'd0) begin
            ht_n = alm_hour_ten - 2'd1;
            hu_n = 4'd9;
          end else begin
            hu_n = alm_hour_unit - 4'd1;
          end
        end else begin
          if (alm_min_unit == 4'd0) begin
            mu_n = 4'd9;
            mt_n = (alm_min_ten == 4'd0) ?
                   4'd5 : alm_min_ten - 4'd1;
          end else begin
            mu_n = alm_min_unit - 4'd1;
          end
        end
      end
    end
  end

  // Alarm time and edited-field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alm_hour_ten  <= 2'd0;
      alm_hour_unit <= 4'd6;
      alm_min_ten   <= 4'd0;
      alm_min_unit  <= 4'd0;
      field_sel     <= 1'b0;
    end else begin
      alm_hour_ten  <= ht_n;
      alm_hour_unit <= hu_n;
      alm_min_ten   <= mt_n;
      alm_min_unit  <= mu_n;
      field_sel     <= fs_n;
    end
  end

  // Ring / snooze sequencing and its counters
  always_comb begin
    st_n   = st;
    ring_n = ring_cnt;
    snz_n  = snz_cnt;
    use_n  = use_cnt;
    if (!alarm_en) begin
      st_n   = IDLE;
      ring_n = '0;
      snz_n  = '0;
      use_n  = '0;
    end else begin
      unique case (st)
        IDLE: st_n = ARMED;
        ARMED: begin
          if (match_ev) begin
            st_n   = RINGING;
            ring_n = '0;
            use_n  = '0;
          end
        end
        RINGING: begin
          if (set_mode || stop) begin
            st_n = ARMED;
          end else if (snooze) begin
            if (use_cnt < USE_MAX) begin
              st_n  = SNOOZE;
              snz_n = SNZ_LOAD;
              use_n = use_cnt + USE_W'(1);
            end else begin
              st_n = ARMED;
            end
          end else if (tick_1s) begin
            ring_n = ring_cnt + 8'd1;
            if (ring_n == RING_MAX) st_n = ARMED;
          end
        end
        SNOOZE: begin
          if (set_mode || stop) begin
            st_n = ARMED;
          end else if (tick_1s) begin
            snz_n = snz_cnt - SNZ_W'(1);
            if (snz_cnt == SNZ_W'(1)) begin
              st_n   = RINGING;
              ring_n = '0;
            end
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  // State, counters, match history and decoded outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      use_cnt  <= '0;
      match_q  <= 1'b0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      st       <= st_n;
      ring_cnt <= ring_n;
      snz_cnt  <= snz_n;
      use_cnt  <= use_n;
      match_q  <= match_c;
      ringing  <= (st_n == RINGING);
      snoozing <= (st_n == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: edit table plus
// ring, snooze, stop, disable and reset sequences.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1s = 1'b0;
  logic [1:0] hour_ten = '0;
  logic [3:0] hour_unit = '0;
  logic [3:0] min_ten = '0;
  logic [3:0] min_unit = '0;
  logic [3:0] sec_ten = '0;
  logic [3:0] sec_unit = '0;
  logic       alarm_en = 1'b0;
  logic       set_mode = 1'b0;
  logic       sel = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] alm_hour_ten;
  logic [3:0] alm_hour_unit;
  logic [3:0] alm_min_ten;
  logic [3:0] alm_min_unit;
  logic       field_sel;
  logic       ringing;
  logic       snoozing;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  alarm_controller dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s),
    .hour_ten(hour_ten), .hour_unit(hour_unit),
    .min_ten(min_ten), .min_unit(min_unit),
    .sec_ten(sec_ten), .sec_unit(sec_unit),
    .alarm_en(alarm_en), .set_mode(set_mode),
    .sel(sel), .up(up), .down(down),
    .snooze(snooze), .stop(stop),
    .alm_hour_ten(alm_hour_ten),
    .alm_hour_unit(alm_hour_unit),
    .alm_min_ten(alm_min_ten),
    .alm_min_unit(alm_min_unit),
    .field_sel(field_sel), .ringing(ringing),
    .snoozing(snoozing), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       up;
    logic       down;
    logic [7:0] h;
    logic [7:0] m;
    logic       fs;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_st(input string nm,
                        input logic [1:0] s);
    chk(nm, {29'd0, state, ringing, snoozing},
        {29'd0, s, s == 2'd2, s == 2'd3});
  endtask

  task automatic chk_alm(input string nm,
                         input logic [7:0] h,
                         input logic [7:0] m,
                         input logic fs);
    chk(nm, {15'd0, 2'b00, alm_hour_ten, alm_hour_unit,
             alm_min_ten, alm_min_unit, field_sel},
        {15'd0, h, m, fs});
  endtask

  task automatic set_time(input int h, input int m,
                          input int s);
    hour_ten  = 2'(h / 10);
    hour_unit = 4'(h % 10);
    min_ten   = 4'(m / 10);
    min_unit  = 4'(m % 10);
    sec_ten   = 4'(s / 10);
    sec_unit  = 4'(s % 10);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1;
      step();
      tick_1s = 1'b0;
    end
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
  endtask

  task automatic edit(input logic s, input logic u,
                      input logic d);
    sel = s; up = u; down = d;
    step();
    sel = 1'b0; up = 1'b0; down = 1'b0;
  endtask

  task automatic ring_up(input string nm);
    set_time(7, 29, 59);
    step();
    chk_st({nm, "_pre"}, 2'd1);
    set_time(7, 30, 0);
    step();
    chk_st(nm, 2'd2);
  endtask

  initial begin
    vecs[0] = '{0, 0, 1, 8'h05, 8'h00, 0};
    vecs[1] = '{0, 1, 0, 8'h06, 8'h00, 0};
    vecs[2] = '{0, 1, 0, 8'h07, 8'h00, 0};
    vecs[3] = '{0, 1, 1, 8'h07, 8'h00, 0};
    vecs[4] = '{1, 0, 0, 8'h07, 8'h00, 1};
    vecs[5] = '{0, 0, 1, 8'h07, 8'h59, 1};
    vecs[6] = '{0, 1, 0, 8'h07, 8'h00, 1};
    vecs[7] = '{0, 1, 0, 8'h07, 8'h01, 1};
    vecs[8] = '{0, 0, 1, 8'h07, 8'h00, 1};
    vecs[9] = '{0, 1, 1, 8'h07, 8'h00, 1};

    set_time(0, 0, 0);
    step();
    step();
    chk_st("reset_state", 2'd0);
    chk_alm("reset_alarm", 8'h06, 8'h00, 1'b0);
    rst_n = 1'b1;
    step();
    chk_st("idle_hold", 2'd0);
    alarm_en = 1'b1;
    step();
    chk_st("armed", 2'd1);

    set_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edit(vecs[i].sel, vecs[i].up, vecs[i].down);
      chk_alm($sformatf("edit_vec%0d", i),
              vecs[i].h, vecs[i].m, vecs[i].fs);
    end
    for (int i = 0; i < 30; i++) begin
      edit(1'b0, 1'b1, 1'b0);
      if (i == 9) chk_alm("min_carry_10", 8'h07, 8'h10, 1'b1);
    end
    chk_alm("alarm_0730", 8'h07, 8'h30, 1'b1);
    set_mode = 1'b0;
    edit(1'b0, 1'b1, 1'b0);
    chk_alm("edit_off", 8'h07, 8'h30, 1'b1);

    ring_up("ring1");
    ticks(59);
    chk_st("ring_59", 2'd2);
    ticks(1);
    chk_st("ring_timeout", 2'd1);
    set_time(7, 30, 1);
    step();
    step();
    chk_st("no_retrigger", 2'd1);

    ring_up("ring2");
    pulse_snooze();
    chk_st("snooze1", 2'd3);
    ticks(100);
    pulse_snooze();
    chk_st("snooze_ignored", 2'd3);
    ticks(199);
    chk_st("snooze1_299", 2'd3);
    ticks(1);
    chk_st("snooze1_end", 2'd2);
    snooze = 1'b1;
    tick_1s = 1'b1;
    step();
    snooze = 1'b0;
    tick_1s = 1'b0;
    chk_st("snooze2_tick", 2'd3);
    ticks(299);
    chk_st("snooze2_299", 2'd3);
    ticks(1);
    chk_st("snooze2_end", 2'd2);
    ticks(30);
    pulse_snooze();
    chk_st("snooze3", 2'd3);
    ticks(300);
    chk_st("snooze3_end", 2'd2);
    ticks(59);
    chk_st("ring_cnt_cleared", 2'd2);
    pulse_snooze();
    chk_st("snooze4_stop", 2'd1);

    ring_up("ring3");
    stop = 1'b1;
    tick_1s = 1'b1;
    step();
    stop = 1'b0;
    tick_1s = 1'b0;
    chk_st("stop_tick", 2'd1);
    ticks(5);
    chk_st("stop_hold", 2'd1);

    ring_up("ring4");
    set_mode = 1'b1;
    step();
    chk_st("setmode_cancel", 2'd1);
    step();
    step();
    chk_st("setmode_gated", 2'd1);
    set_mode = 1'b0;
    step();
    chk_st("setmode_exit_ring", 2'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_st("stop_plain", 2'd1);

    ring_up("ring5");
    pulse_snooze();
    chk_st("snooze5", 2'd3);
    alarm_en = 1'b0;
    step();
    chk_st("disable_idle", 2'd0);
    chk_alm("disable_keep", 8'h07, 8'h30, 1'b1);
    set_time(8, 0, 0);
    alarm_en = 1'b1;
    step();
    chk_st("reenable", 2'd1);
    ticks(400);
    chk_st("reenable_quiet", 2'd1);

    ring_up("ring6");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    alarm_en = 1'b0;
    #1;
    chk_st("async_reset", 2'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_st("post_reset_state", 2'd0);
    chk_alm("post_reset_alarm", 8'h06, 8'h00, 1'b0);

    set_mode = 1'b1;
    for (int i = 0; i < 6; i++) edit(1'b0, 1'b0, 1'b1);
    chk_alm("hour_00", 8'h00, 8'h00, 1'b0);
    edit(1'b0, 1'b0, 1'b1);
    chk_alm("hour_wrap_23", 8'h23, 8'h00, 1'b0);
    edit(1'b0, 1'b1, 1'b0);
    chk_alm("hour_wrap_00", 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) edit(1'b0, 1'b1, 1'b0);
    chk_alm("hour_carry_10", 8'h10, 8'h00, 1'b0);
    edit(1'b0, 1'b0, 1'b1);
    chk_alm("hour_borrow_09", 8'h09, 8'h00, 1'b0);
    chk_st("edit_idle", 2'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm scheduler for the century clock. It holds a programmable BCD alarm time (hh:mm) and compares it against the running time from the hour, minute and second counters. On a match it sequences a ring / snooze / stop cycle. It sits beside the control unit in the 1 Hz domain, drives a ringer output, and exports the alarm digits to the display path.

## Interface
Parameters:
- SNOOZE_MIN, 5: snooze length in minutes (1–59).
- RING_TIMEOUT_S, 60: seconds of unattended ringing before auto-stop (1–255).
- MAX_SNOOZE, 3: snoozes allowed per alarm event; once used up, snooze acts as stop.

Ports:
- clk  in  1  block clock, same clock as the time counters.
- rst_n  in  1  reset; one clock, asynchronous, active-low reset.
- tick_1s  in  1  one-cycle enable, once per second; all internal timers advance only on it.
- hour_ten  in  2  current hour tens (BCD). hour_unit  in  4  current hour units.
- min_ten  in  4  / min_unit  in  4  current minute digits.
- sec_ten  in  4  / sec_unit  in  4  current second digits.
- alarm_en  in  1  level: alarm armed when 1.
- set_mode  in  1  level: alarm-time edit mode.
- sel  in  1  pulse: toggle edited field (hour ↔ minute).
- up, down  in  1  pulses: increment/decrement the edited field.
- snooze, stop  in  1  pulses from conditioned buttons.
- alm_hour_ten  out  2, alm_hour_unit  out  4, alm_min_ten  out  4, alm_min_unit  out  4: stored alarm time.
- field_sel  out  1  0 = hour, 1 = minute (drives display blink).
- ringing  out  1  ringer drive.
- snoozing  out  1  high in SNOOZE.
- state  out  2  IDLE = 0, ARMED = 1, RINGING = 2, SNOOZE = 3.

## Operation
- All outputs are registered.
- Reset values:
  - alarm time 06:00.
  - field_sel = 0.
  - state IDLE; ringing = 0, snoozing = 0.
  - snooze counter, ring counter and snooze-use counter = 0.
- Edit path:
  - Edits occur only while set_mode = 1. sel toggles field_sel.
  - Hour wraps 23→00 on up and 00→23 on down. Minute wraps 59→00 and 00→59.
  - BCD carries are handled per digit, e.g. 09→10 and 10→09.
  - up and down asserted in the same cycle: no change. No carry from minute into hour.
- Match: `match` is true when alarm_en = 1, set_mode = 0, and current hh:mm equals the alarm hh:mm with ss = 00. A match event is the rising edge of `match`, using a registered copy.
- FSM transitions:
  - IDLE → ARMED when alarm_en = 1.
  - ARMED → RINGING on a match event. On entry, ring counter = 0 and snooze-use counter = 0.
  - RINGING:
    - stop → ARMED.
    - snooze with uses < MAX_SNOOZE → SNOOZE; snooze counter loads SNOOZE_MIN×60 and uses increments.
    - snooze with uses = MAX_SNOOZE → ARMED.
    - otherwise, the ring counter increments on tick_1s; reaching RING_TIMEOUT_S → ARMED.
  - SNOOZE:
    - stop → ARMED.
    - the snooze counter decrements on tick_1s; reaching 0 → RINGING with the ring counter cleared. Snooze in this state is ignored.
  - alarm_en = 0 in any state → IDLE next cycle; all counters are cleared and the alarm time is retained.
  - set_mode = 1 in RINGING or SNOOZE → ARMED (when alarm_en = 1); ringing is cancelled.
- Priority within a cycle: alarm_en low > set_mode > stop > snooze > timer expiry > match.
- Output decode: ringing = (state == RINGING); snoozing = (state == SNOOZE).
- Counter widths:
  - snooze counter: ceil(log2(SNOOZE_MIN×60 + 1)) bits.
  - ring counter: 8 bits.
  - snooze-use counter: ceil(log2(MAX_SNOOZE + 1)) bits.
- A match event while already in RINGING or SNOOZE is ignored.
- Editing the alarm to the current hh:mm while ss = 00 does not ring, because match is gated off during set_mode. Leaving set_mode during that same second does ring, since a fresh rising edge occurs.

## Timing
- Match event to ringing = 1: one clk cycle (registered edge detect plus state register; ringing is decoded from the state register).
- stop or snooze pulse to ringing = 0: one cycle.
- up/down pulse to updated alarm digits: one cycle.
- Snooze duration: exactly SNOOZE_MIN×60 tick_1s pulses after the snooze pulse, then RINGING on the cycle following the final tick.
- Ring timeout: after RING_TIMEOUT_S ticks in RINGING, state is ARMED on the next cycle.
- Asynchronous reset mid-ring: ringing drops immediately, state = IDLE, alarm time = 06:00.
- A tick_1s coinciding with a stop/snooze pulse: the pulse wins and the counter update is discarded.

## Test plan
- Reset, alarm_en = 1, set_mode edits to 07:30 (sel, up ×1 hour, up ×30 min) → alm digits 0,7,3,0; time 07:29:59 → 07:30:00 → ringing = 1 one cycle later, state = 2.
- Ringing, no input, 60 ticks → state = 1, ringing = 0; time 07:30:01 causes no re-trigger.
- Ringing, snooze → state = 3; after 300 ticks → ringing = 1. Snooze twice more, then a 4th snooze → state = 1 (MAX_SNOOZE = 3).
- Edit wrap: hour at 00, down → 23; minute at 59, up → 00 with hour unchanged; up & down together → no change.
- In SNOOZE, alarm_en → 0 → state = 0 next cycle. Re-enable → state = 1, snooze counter cleared, no ring until the next match.
- Assert rst_n low while ringing → ringing = 0 asynchronously; after release, all outputs hold their reset values (06:00, state = 0).
